alu_mdu: RTL and testbench
==========================

Name: alu_mdu

Overview:
- Parametrised, pipelined successor to the single-cycle datapath ALU.
- Adds a valid/ready handshake on input and output, extended RV32-style logic and shift ops, and iterative multiply, unsigned divide and unsigned remainder.
- Sits between the operand mux and writeback in the multi-cycle core. The control FSM stalls on `in_ready` and `out_valid`.

Parameters:
- WIDTH, 32: operand and result width in bits; must be ≥ 4 and even.
- SHAMT_W, $clog2(WIDTH): number of low bits of `b` used as the shift amount.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op are presented this cycle.
- in_ready  output  1  block can accept a new operation this cycle.
- a  input  WIDTH  operand A (RD1).
- b  input  WIDTH  operand B (srcb).
- ALUControl  input  4  op code, `alu_op_t`.
- out_valid  output  1  result, zero and illegal are valid.
- out_ready  input  1  consumer takes the result this cycle.
- alu_result  output  WIDTH  registered result.
- zero  output  1  registered (a == b) for the accepted operation.
- illegal  output  1  accepted op code was unassigned.

Behaviour:
- Op codes:
  - 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR; 0101 SLT (signed); 0110 SLTU.
  - 0111 SLL; 1000 SRL; 1001 SRA, each shifting by b[SHAMT_W-1:0].
  - 1010 MUL (low WIDTH bits of the product); 1011 DIVU; 1100 REMU.
  - 1101–1111 illegal.
- Add and subtract wrap modulo 2^WIDTH with no carry or overflow output. SLT and SLTU produce 1 or 0, zero-extended to WIDTH.
- Accept condition: in_valid && in_ready. Operands and op are captured on the accept edge; inputs are ignored at all other times.
- in_ready = (state == IDLE) && (!out_valid || out_ready). Back-to-back accepts are allowed while the output drains in the same cycle.
- FSM states: IDLE, MUL, DIV.
  - IDLE + accept of a single-cycle op or illegal op: the result is registered on the accept edge. out_valid rises on the next cycle, so latency is 1. State stays IDLE.
  - IDLE + accept of MUL: go to MUL and load counter = WIDTH. Each cycle performs one shift-add step (multiplicand shifted left, multiplier shifted right) and decrements the counter.
  - MUL with counter reaching 0: write alu_result, set out_valid, return to IDLE. Latency from accept to out_valid is WIDTH + 1 cycles.
  - IDLE + accept of DIVU or REMU: go to DIV and run a WIDTH-step restoring divider with a WIDTH+1-bit partial remainder. Latency is WIDTH + 1. The result is the quotient or the remainder according to the captured op.
  - Divide by zero still takes the full WIDTH + 1 cycles and gives quotient = all ones, remainder = a, with no error flag.
- Counter width is $clog2(WIDTH+1).
- Output register:
  - out_valid, alu_result, zero and illegal hold steady while out_valid && !out_ready.
  - out_valid clears on an out_ready handshake unless a new result is written on the same edge; in that case the new result wins and out_valid stays 1.
- zero is computed from the captured operands for every op, multi-cycle ops included.
- Illegal op: alu_result = 0, illegal = 1, latency 1, no state change.
- out_ready high while out_valid = 0 has no effect.
- Reset (any state, including mid-MUL or mid-DIV):
  - Next edge: state = IDLE, out_valid = 0, alu_result = 0, zero = 0, illegal = 0, counter = 0.
  - in_ready is 1 in the first cycle after reset is released.
  - A partial operation is discarded and produces no output.
- in_valid while busy: not accepted because in_ready = 0. The source must hold the request; there is no queueing.

Decomposition:
- Package `alu_pkg`:
  - `alu_op_t` 4-bit enum with the codes above.
  - `alu_state_t` enum {IDLE, MUL, DIV}.
  - Helper function `is_multicycle(alu_op_t)`.
- Sub-module `alu_iter_muldiv`: the shared shift-add / restoring-divide datapath.
  - Inputs: start, is_div, a, b.
  - Outputs: done, product_lo, quotient, remainder.
- The top level owns the FSM handshake, the single-cycle ops and the output register.

Test Plan (WIDTH = 32):
- Single-cycle ops:
  - ADD a=0xFFFFFFFF, b=1 → out_valid one cycle after accept, alu_result=0x00000000, zero=0.
  - SUB a=5, b=5 → alu_result=0, zero=1.
  - SLT a=0xFFFFFFFF, b=1 → 1; SLTU with the same operands → 0.
- Shifts:
  - SRA a=0x80000000, b=0x21 (shamt 1) → 0xC0000000.
  - SRL with the same operands → 0x40000000.
  - SLL a=1, b=31 → 0x80000000.
- Multiply: MUL a=0x0001_0003, b=0x0002_0005 → in_ready=0 for 32 cycles, out_valid at accept+33, alu_result=0x000B_000F (low word).
- Divide:
  - DIVU a=100, b=7 → 14; REMU with the same operands → 2.
  - DIVU a=9, b=0 → 0xFFFFFFFF; REMU a=9, b=0 → 9. Each with latency 33.
- Output backpressure: hold out_ready=0 for 5 cycles after an ADD result → result stable and in_ready=0 throughout. Then raise out_ready with a new in_valid in the same cycle → the new op is accepted and the next result appears one cycle later with no bubble.
- Reset and illegal op:
  - Assert reset at cycle 10 of a MUL → next cycle out_valid=0, in_ready=1, and no stale result ever appears.
  - ALUControl=1110 → illegal=1, alu_result=0, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM states and op classification shared by alu_mdu
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLT  = 4'b0101,
    OP_SLTU = 4'b0110,
    OP_SLL  = 4'b0111,
    OP_SRL  = 4'b1000,
    OP_SRA  = 4'b1001,
    OP_MUL  = 4'b1010,
    OP_DIVU = 4'b1011,
    OP_REMU = 4'b1100
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } alu_state_t;

  function automatic logic is_multicycle(input alu_op_t op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// rtl/alu_iter_muldiv.sv - shared iterative shift-add multiplier / restoring divider
// Outputs present the value the final step will write, so the caller registers them on done.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] r_count;
  logic             r_is_div;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;

  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_x_nxt;
  logic [WIDTH-1:0] w_y_nxt;

  // mul: r_x = multiplier (shifts right), r_y = multiplicand (shifts left), r_acc = product
  // div: r_x = dividend becoming quotient, r_y = divisor, r_acc = partial remainder
  always_comb begin
    w_shift   = {r_acc, r_x[WIDTH-1]};
    w_ge      = (w_shift >= {1'b0, r_y});
    w_acc_nxt = r_acc;
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    if (r_is_div) begin
      // true difference is below the divisor, so the low WIDTH bits are exact
      w_acc_nxt = w_ge ? (w_shift[WIDTH-1:0] - r_y) : w_shift[WIDTH-1:0];
      w_x_nxt   = {r_x[WIDTH-2:0], w_ge};
    end else begin
      w_acc_nxt = r_acc + (r_x[0] ? r_y : '0);
      w_x_nxt   = r_x >> 1;
      w_y_nxt   = r_y << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (start) begin
      r_count <= CNT_W'(WIDTH);
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      r_is_div <= is_div;
      r_acc    <= '0;
      r_x      <= is_div ? a : b;
      r_y      <= is_div ? b : a;
    end else if (r_count != '0) begin
      r_acc <= w_acc_nxt;
      r_x   <= w_x_nxt;
      r_y   <= w_y_nxt;
    end
  end

  assign done       = (r_count == CNT_W'(1));
  assign product_lo = w_acc_nxt;
  assign quotient   = w_x_nxt;
  assign remainder  = w_acc_nxt;

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - handshaked ALU with single-cycle ops and iterative MUL/DIVU/REMU
// Owns the IDLE/MUL/DIV FSM, the single-cycle datapath and the output register.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             illegal
);

  alu_state_t r_state;
  alu_state_t w_state_nxt;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;
  logic             r_zero_cap;
  logic             r_rem_sel;

  alu_op_t          w_op;
  logic [SHAMT_W-1:0] w_shamt;
  logic             w_accept;
  logic             w_start;
  logic [WIDTH-1:0] w_sc_result;
  logic             w_sc_illegal;
  logic             w_write;
  logic [WIDTH-1:0] w_wr_result;
  logic             w_wr_zero;
  logic             w_wr_illegal;

  logic             w_md_done;
  logic [WIDTH-1:0] w_product_lo;
  logic [WIDTH-1:0] w_quotient;
  logic [WIDTH-1:0] w_remainder;

  assign w_op     = alu_op_t'(ALUControl);
  assign w_shamt  = b[SHAMT_W-1:0];
  assign in_ready = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_start  = w_accept && is_multicycle(w_op);

  always_comb begin
    w_sc_result  = '0;
    w_sc_illegal = 1'b0;
    case (w_op)
      OP_ADD:  w_sc_result = a + b;
      OP_SUB:  w_sc_result = a - b;
      OP_AND:  w_sc_result = a & b;
      OP_OR:   w_sc_result = a | b;
      OP_XOR:  w_sc_result = a ^ b;
      OP_SLT:  w_sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_sc_result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  w_sc_result = a << w_shamt;
      OP_SRL:  w_sc_result = a >> w_shamt;
      OP_SRA:  w_sc_result = $signed(a) >>> w_shamt;
      OP_MUL, OP_DIVU, OP_REMU: w_sc_result = '0;
      default: w_sc_illegal = 1'b1;
    endcase
  end

  alu_iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start     (w_start),
    .is_div    (w_op != OP_MUL),
    .a         (a),
    .b         (b),
    .done      (w_md_done),
    .product_lo(w_product_lo),
    .quotient  (w_quotient),
    .remainder (w_remainder)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_write      = 1'b0;
    w_wr_result  = w_sc_result;
    w_wr_zero    = (a == b);
    w_wr_illegal = w_sc_illegal;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (is_multicycle(w_op)) begin
            w_state_nxt = (w_op == OP_MUL) ? MUL : DIV;
          end else begin
            w_write = 1'b1;
          end
        end
      end
      MUL: begin
        if (w_md_done) begin
          w_write      = 1'b1;
          w_wr_result  = w_product_lo;
          w_wr_zero    = r_zero_cap;
          w_wr_illegal = 1'b0;
          w_state_nxt  = IDLE;
        end
      end
      DIV: begin
        if (w_md_done) begin
          w_write      = 1'b1;
          w_wr_result  = r_rem_sel ? w_remainder : w_quotient;
          w_wr_zero    = r_zero_cap;
          w_wr_illegal = 1'b0;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_start) begin
      r_zero_cap <= (a == b);
      r_rem_sel  <= (w_op == OP_REMU);
    end
  end

  // a freshly written result wins over draining the previous one
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_write) begin
      r_out_valid <= 1'b1;
      r_result    <= w_wr_result;
      r_zero      <= w_wr_zero;
      r_illegal   <= w_wr_illegal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign alu_result = r_result;
  assign zero       = r_zero;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - self-checking bench for alu_mdu against a behavioural model
module tb_alu_mdu;

  localparam int W   = 32;
  localparam int TMO = 200;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   ALUControl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_result;
  logic         zero;
  logic         illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ALUControl(ALUControl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_result(alu_result),
    .zero      (zero),
    .illegal   (illegal)
  );

  // {illegal, result} from plain arithmetic on the op definitions
  function automatic logic [W:0] ref_alu(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    logic [W-1:0]   r;
    logic           ill;
    int             sh;
    ill = 1'b0;
    r   = '0;
    sh  = int'(y % W);
    case (op)
      4'd0:  r = x + y;
      4'd1:  r = x - y;
      4'd2:  r = x & y;
      4'd3:  r = x | y;
      4'd4:  r = x ^ y;
      4'd5:  r = ($signed(x) < $signed(y)) ? 1 : 0;
      4'd6:  r = (x < y) ? 1 : 0;
      4'd7:  r = x << sh;
      4'd8:  r = x >> sh;
      4'd9:  r = $signed(x) >>> sh;
      4'd10: begin p = {{W{1'b0}}, x} * {{W{1'b0}}, y}; r = p[W-1:0]; end
      4'd11: r = (y == 0) ? {W{1'b1}} : x / y;
      4'd12: r = (y == 0) ? x : x % y;
      default: ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
    return (op >= 4'd10 && op <= 4'd12) ? W + 1 : 1;
  endfunction

  // drive one op, then report latency, busy cycles and the first valid output
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] oa, input logic [W-1:0] ob,
                       output int lat, output int busy, output logic [W-1:0] res,
                       output logic z, output logic ill);
    int guard;
    guard = 0;
    while (!in_ready && guard < TMO) begin
      @(posedge clk); #1;
      guard++;
    end
    ALUControl = op;
    a          = oa;
    b          = ob;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    a          = $urandom;
    b          = $urandom;
    ALUControl = 4'($urandom);
    lat  = 1;
    busy = 0;
    while (!out_valid && lat < TMO) begin
      if (!in_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    res = alu_result;
    z   = zero;
    ill = illegal;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; ALUControl = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (alu_result !== '0) begin bad++; $display("FAIL reset_result got=%h exp=0", alu_result); end
    total++; if (zero !== 1'b0 || illegal !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", zero, illegal); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single_cycle();
    logic [3:0]   ops [4] = '{4'd0, 4'd1, 4'd5, 4'd6};
    logic [W-1:0] as  [4] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] bs  [4] = '{32'd1, 32'd5, 32'd1, 32'd1};
    logic [W-1:0] exr [4] = '{32'h0, 32'h0, 32'h1, 32'h0};
    logic         exz [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int lat, busy;
    logic [W-1:0] res;
    logic z, ill;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], lat, busy, res, z, ill);
      total++; if (res !== exr[i]) begin bad++; $display("FAIL single_result[%0d] got=%h exp=%h", i, res, exr[i]); end
      total++; if (z !== exz[i]) begin bad++; $display("FAIL single_zero[%0d] got=%b exp=%b", i, z, exz[i]); end
      total++; if (lat != 1) begin bad++; $display("FAIL single_latency[%0d] got=%0d exp=1", i, lat); end
    end
  endtask

  task automatic test_shifts();
    logic [3:0]   ops [3] = '{4'd9, 4'd8, 4'd7};
    logic [W-1:0] as  [3] = '{32'h8000_0000, 32'h8000_0000, 32'h1};
    logic [W-1:0] bs  [3] = '{32'h21, 32'h21, 32'd31};
    logic [W-1:0] exr [3] = '{32'hC000_0000, 32'h4000_0000, 32'h8000_0000};
    int lat, busy;
    logic [W-1:0] res;
    logic z, ill;
    for (int i = 0; i < 3; i++) begin
      do_op(ops[i], as[i], bs[i], lat, busy, res, z, ill);
      total++; if (res !== exr[i]) begin bad++; $display("FAIL shift_result[%0d] got=%h exp=%h", i, res, exr[i]); end
    end
  endtask

  task automatic test_mul();
    int lat, busy;
    logic [W-1:0] res;
    logic z, ill;
    do_op(4'd10, 32'h0001_0003, 32'h0002_0005, lat, busy, res, z, ill);
    total++; if (res !== 32'h000B_000F) begin bad++; $display("FAIL mul_result got=%h exp=000b000f", res); end
    total++; if (lat != 33) begin bad++; $display("FAIL mul_latency got=%0d exp=33", lat); end
    total++; if (busy != 32) begin bad++; $display("FAIL mul_busy got=%0d exp=32", busy); end
    total++; if (z !== 1'b0 || ill !== 1'b0) begin bad++; $display("FAIL mul_flags got=%b%b exp=00", z, ill); end
  endtask

  task automatic test_div();
    logic [3:0]   ops [4] = '{4'd11, 4'd12, 4'd11, 4'd12};
    logic [W-1:0] as  [4] = '{32'd100, 32'd100, 32'd9, 32'd9};
    logic [W-1:0] bs  [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
    logic [W-1:0] exr [4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9};
    int lat, busy;
    logic [W-1:0] res;
    logic z, ill;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], lat, busy, res, z, ill);
      total++; if (res !== exr[i]) begin bad++; $display("FAIL div_result[%0d] got=%h exp=%h", i, res, exr[i]); end
      total++; if (lat != 33) begin bad++; $display("FAIL div_latency[%0d] got=%0d exp=33", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, busy;
    logic [W-1:0] res;
    logic z, ill;
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_op(4'd0, 32'd3, 32'd4, lat, busy, res, z, ill);
    total++; if (res !== 32'd7 || lat != 1) begin bad++; $display("FAIL bp_first got=%h lat=%0d exp=7 lat=1", res, lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, alu_result} !== {1'b1, 1'b0, 32'd7}) begin
        bad++;
        $display("FAIL bp_hold[%0d] got valid=%b ready=%b res=%h exp valid=1 ready=0 res=7", i, out_valid, in_ready, alu_result);
      end
    end
    out_ready  = 1'b1;
    ALUControl = 4'd4;
    a          = 32'hF0;
    b          = 32'h0F;
    in_valid   = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_on_drain got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if ({out_valid, alu_result} !== {1'b1, 32'hFF}) begin
      bad++;
      $display("FAIL bp_no_bubble got valid=%b res=%h exp valid=1 res=ff", out_valid, alu_result);
    end
  endtask

  task automatic test_illegal();
    int lat, busy;
    logic [W-1:0] res;
    logic [W-1:0] v;
    logic z, ill;
    v = $urandom;
    do_op(4'b1110, v, v, lat, busy, res, z, ill);
    total++; if (ill !== 1'b1) begin bad++; $display("FAIL illegal_flag got=%b exp=1", ill); end
    total++; if (res !== '0) begin bad++; $display("FAIL illegal_result got=%h exp=0", res); end
    total++; if (lat != 1) begin bad++; $display("FAIL illegal_latency got=%0d exp=1", lat); end
    total++; if (z !== 1'b1) begin bad++; $display("FAIL illegal_zero got=%b exp=1", z); end
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    int guard;
    guard = 0;
    while (!in_ready && guard < TMO) begin @(posedge clk); #1; guard++; end
    ALUControl = 4'd10;
    a          = 32'h1234_5678;
    b          = 32'h9ABC_DEF0;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midmul_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midmul_in_ready got=%b exp=1", in_ready); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midmul_stale got=%0d valid cycles exp=0", seen); end
  endtask

  task automatic test_random();
    int lat, busy;
    logic [W-1:0] res, x, y;
    logic z, ill;
    logic [3:0] op;
    logic [W:0] exp_v;
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      x  = $urandom;
      case ($urandom_range(0, 3))
        0: y = $urandom;
        1: y = W'($urandom_range(0, 9));
        2: y = x;
        default: y = '0;
      endcase
      exp_v = ref_alu(op, x, y);
      do_op(op, x, y, lat, busy, res, z, ill);
      total++;
      if ({ill, res} !== exp_v) begin
        bad++;
        $display("FAIL rand_result[%0d] op=%0d a=%h b=%h got=%b/%h exp=%b/%h", n, op, x, y, ill, res, exp_v[W], exp_v[W-1:0]);
      end
      total++; if (z !== (x == y)) begin bad++; $display("FAIL rand_zero[%0d] got=%b exp=%b", n, z, (x == y)); end
      total++; if (lat != ref_lat(op)) begin bad++; $display("FAIL rand_latency[%0d] op=%0d got=%0d exp=%0d", n, op, lat, ref_lat(op)); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_cycle();
    test_shifts();
    test_mul();
    test_div();
    test_back_to_back();
    test_illegal();
    test_reset_mid_mul();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
